// File: rtl/intra4x4_mode_sched.sv
// Intra 4x4 luma mode scheduler: issues the 16 blocks of a macroblock in
// double-Z order, collects the chosen modes, predicts each mode from its
// left/top neighbours and emits the prev-flag / rem-mode pair for entropy coding.
module intra4x4_mode_sched #(
  parameter int MB_W_MAX = 120,
  parameter int MBX_W    = 7,
  parameter int MBY_W    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mb_start,
  input  logic [MBX_W-1:0] mb_x,
  input  logic [MBY_W-1:0] mb_y,
  output logic             mb_busy,
  output logic             mb_done,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic [3:0]       blk_idx,
  output logic [3:0]       blk_x,
  output logic [3:0]       blk_y,
  output logic             mbAddrA_valid,
  output logic             mbAddrB_valid,
  input  logic             res_valid,
  input  logic [3:0]       res_mode,
  output logic             res_ready,
  output logic             mode_valid,
  output logic             prev_flag,
  output logic [2:0]       rem_mode
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CODE  = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  localparam int LB_N  = MB_W_MAX * 4;
  localparam int LB_AW = $clog2(LB_N);

  logic [2:0]       state_q, state_d;
  logic [3:0]       blk_idx_q, blk_idx_d;
  logic [MBX_W-1:0] mb_x_q, mb_x_d;
  logic [MBY_W-1:0] mb_y_q, mb_y_d;
  logic [3:0]       res_mode_q, res_mode_d;
  // Mode array is indexed in raster order {row, col} of 4x4 blocks.
  logic [3:0]       mode_arr_q [16];
  logic [3:0]       mode_arr_d [16];
  logic [3:0]       left_q [4];
  logic [3:0]       left_d [4];
  logic [3:0]       linebuf_q [LB_N];
  logic             lb_we;

  logic [1:0]       bx, by, bx_m1, by_m1;
  logic [LB_AW-1:0] lb_base;
  logic             avail_a, avail_b;
  logic [3:0]       mode_a, mode_b, pred;
  logic             prev_c;
  logic [2:0]       rem_c;

  // Neighbour lookup and mode prediction for the block currently in flight
  always_comb begin
    bx      = {blk_idx_q[2], blk_idx_q[0]};
    by      = {blk_idx_q[3], blk_idx_q[1]};
    bx_m1   = bx - 2'd1;
    by_m1   = by - 2'd1;
    lb_base = LB_AW'({mb_x_q, 2'b00});
    avail_a = (bx != 2'd0) || (mb_x_q != '0);
    avail_b = (by != 2'd0) || (mb_y_q != '0);
    mode_a  = (bx != 2'd0) ? mode_arr_q[{by, bx_m1}] : left_q[by];
    mode_b  = (by != 2'd0) ? mode_arr_q[{by_m1, bx}] : linebuf_q[lb_base + LB_AW'(bx)];
    if (avail_a && avail_b)
      pred = (mode_a < mode_b) ? mode_a : mode_b;
    else
      pred = 4'd2;
    prev_c = (res_mode_q == pred);
    // Above pred the low three bits minus one also map mode 8 onto 7.
    if (prev_c)
      rem_c = 3'd0;
    else if (res_mode_q < pred)
      rem_c = res_mode_q[2:0];
    else
      rem_c = res_mode_q[2:0] - 3'd1;
  end

  // Output decode from the current state
  always_comb begin
    mb_busy       = (state_q != S_IDLE);
    blk_valid     = (state_q == S_ISSUE);
    res_ready     = (state_q == S_WAIT);
    mode_valid    = (state_q == S_CODE);
    mb_done       = (state_q == S_FLUSH);
    prev_flag     = (state_q == S_CODE) && prev_c;
    rem_mode      = (state_q == S_CODE) ? rem_c : 3'd0;
    blk_idx       = blk_idx_q;
    blk_x         = {bx, 2'b00};
    blk_y         = {by, 2'b00};
    mbAddrA_valid = mb_busy && avail_a;
    mbAddrB_valid = mb_busy && avail_b;
  end

  // Scheduler FSM and mode storage next-state
  always_comb begin
    state_d    = state_q;
    blk_idx_d  = blk_idx_q;
    mb_x_d     = mb_x_q;
    mb_y_d     = mb_y_q;
    res_mode_d = res_mode_q;
    mode_arr_d = mode_arr_q;
    left_d     = left_q;
    lb_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mb_start) begin
          mb_x_d    = mb_x;
          mb_y_d    = mb_y;
          blk_idx_d = 4'd0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (blk_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (res_valid) begin
          res_mode_d = res_mode;
          state_d    = S_CODE;
        end
      end
      S_CODE: begin
        mode_arr_d[{by, bx}] = res_mode_q;
        if (blk_idx_q == 4'd15) begin
          state_d = S_FLUSH;
        end else begin
          blk_idx_d = blk_idx_q + 4'd1;
          state_d   = S_ISSUE;
        end
      end
      S_FLUSH: begin
        for (int r = 0; r < 4; r++) left_d[r] = mode_arr_q[4'(r * 4 + 3)];
        lb_we   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and mode-storage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      blk_idx_q  <= 4'd0;
      mb_x_q     <= '0;
      mb_y_q     <= '0;
      res_mode_q <= 4'd0;
      for (int i = 0; i < 16; i++) mode_arr_q[i] <= 4'd0;
      for (int r = 0; r < 4; r++) left_q[r] <= 4'd0;
    end else begin
      state_q    <= state_d;
      blk_idx_q  <= blk_idx_d;
      mb_x_q     <= mb_x_d;
      mb_y_q     <= mb_y_d;
      res_mode_q <= res_mode_d;
      mode_arr_q <= mode_arr_d;
      left_q     <= left_d;
      if (state_q == S_WAIT && res_valid)
        assert (res_mode <= 4'd8);
    end
  end

  // Top-mode line buffer: bottom row of the finished MB, no reset
  always_ff @(posedge clk) begin
    if (lb_we && !rst)
      for (int c = 0; c < 4; c++)
        linebuf_q[lb_base + LB_AW'(c)] <= mode_arr_q[4'(12 + c)];
  end

endmodule

// File: tb/tb_intra4x4_mode_sched.sv
// Directed bench for intra4x4_mode_sched with hand-computed mode coding results.
module tb_intra4x4_mode_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mb_start = 1'b0;
  logic [6:0] mb_x = '0;
  logic [6:0] mb_y = '0;
  logic       mb_busy, mb_done, blk_valid;
  logic       blk_ready = 1'b0;
  logic [3:0] blk_idx, blk_x, blk_y;
  logic       mbAddrA_valid, mbAddrB_valid;
  logic       res_valid = 1'b0;
  logic [3:0] res_mode = '0;
  logic       res_ready, mode_valid, prev_flag;
  logic [2:0] rem_mode;

  int checks = 0;
  int errors = 0;

  int xt [16] = '{0, 4, 0, 4, 8, 12, 8, 12, 0, 4, 0, 4, 8, 12, 8, 12};
  int yt [16] = '{0, 0, 4, 4, 0, 0, 4, 4, 8, 8, 12, 12, 8, 8, 12, 12};
  logic [15:0] pm;

  intra4x4_mode_sched #(.MB_W_MAX(120), .MBX_W(7), .MBY_W(7)) dut (
    .clk(clk), .rst(rst), .mb_start(mb_start), .mb_x(mb_x), .mb_y(mb_y),
    .mb_busy(mb_busy), .mb_done(mb_done), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_idx(blk_idx), .blk_x(blk_x), .blk_y(blk_y),
    .mbAddrA_valid(mbAddrA_valid), .mbAddrB_valid(mbAddrB_valid),
    .res_valid(res_valid), .res_mode(res_mode), .res_ready(res_ready),
    .mode_valid(mode_valid), .prev_flag(prev_flag), .rem_mode(rem_mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " mb_busy"}, mb_busy, 0);
    check({tag, " mb_done"}, mb_done, 0);
    check({tag, " blk_valid"}, blk_valid, 0);
    check({tag, " res_ready"}, res_ready, 0);
    check({tag, " mode_valid"}, mode_valid, 0);
    check({tag, " prev_flag"}, prev_flag, 0);
    check({tag, " rem_mode"}, rem_mode, 0);
    check({tag, " blk_idx"}, blk_idx, 0);
    check({tag, " blk_x"}, blk_x, 0);
    check({tag, " blk_y"}, blk_y, 0);
    check({tag, " mbAddrA_valid"}, mbAddrA_valid, 0);
    check({tag, " mbAddrB_valid"}, mbAddrB_valid, 0);
  endtask

  task automatic start_mb(input logic [6:0] x, input logic [6:0] y);
    @(negedge clk);
    mb_start = 1'b1;
    mb_x = x;
    mb_y = y;
    @(negedge clk);
    mb_start = 1'b0;
    check("mb_busy after start", mb_busy, 1);
  endtask

  // One block: issue handshake, result handshake, then check coded fields.
  task automatic run_block(input int idx, input logic [3:0] mode, input logic exp_prev,
                           input logic [2:0] exp_rem, input int exp_a, input int exp_b);
    for (int k = 0; k < 20; k++) begin
      if (blk_valid) break;
      @(negedge clk);
    end
    check($sformatf("blk_valid b%0d", idx), blk_valid, 1);
    check($sformatf("blk_idx b%0d", idx), blk_idx, idx);
    check($sformatf("blk_x b%0d", idx), blk_x, xt[idx]);
    check($sformatf("blk_y b%0d", idx), blk_y, yt[idx]);
    if (exp_a >= 0) check($sformatf("mbAddrA_valid b%0d", idx), mbAddrA_valid, exp_a);
    if (exp_b >= 0) check($sformatf("mbAddrB_valid b%0d", idx), mbAddrB_valid, exp_b);
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    check($sformatf("res_ready b%0d", idx), res_ready, 1);
    res_valid = 1'b1;
    res_mode = mode;
    @(negedge clk);
    res_valid = 1'b0;
    check($sformatf("mode_valid b%0d", idx), mode_valid, 1);
    check($sformatf("prev_flag b%0d", idx), prev_flag, exp_prev);
    check($sformatf("rem_mode b%0d", idx), rem_mode, exp_rem);
  endtask

  task automatic finish_mb();
    check("mb_done early", mb_done, 0);
    @(negedge clk);
    check("mb_done pulse", mb_done, 1);
    @(negedge clk);
    check("mb_done clear", mb_done, 0);
    check("mb_busy clear", mb_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("post-reset");

    // MB(0,0) all mode 4; scan order checked in run_block
    pm = 16'hFAC8;
    start_mb(7'd0, 7'd0);
    for (int i = 0; i < 16; i++)
      run_block(i, 4'd4, pm[i], pm[i] ? 3'd0 : 3'd3, int'(xt[i] != 0), int'(yt[i] != 0));
    finish_mb();

    // MB(0,0) all mode 6
    start_mb(7'd0, 7'd0);
    for (int i = 0; i < 16; i++)
      run_block(i, 4'd6, pm[i], pm[i] ? 3'd0 : 3'd5, int'(xt[i] != 0), int'(yt[i] != 0));
    finish_mb();

    // MB(1,0): block0 mode 1 with A=6 from left reg, B unavailable; rest mode 3
    pm = 16'hFFC8;
    start_mb(7'd1, 7'd0);
    run_block(0, 4'd1, 1'b0, 3'd1, 1, 0);
    for (int i = 1; i < 16; i++)
      run_block(i, 4'd3, pm[i], pm[i] ? 3'd0 : 3'd2, 1, int'(yt[i] != 0));
    finish_mb();

    // MB(0,0) all mode 3, leaving bottom row 3 in linebuf
    pm = 16'hFAC8;
    start_mb(7'd0, 7'd0);
    for (int i = 0; i < 16; i++)
      run_block(i, 4'd3, pm[i], pm[i] ? 3'd0 : 3'd2, int'(xt[i] != 0), int'(yt[i] != 0));
    finish_mb();

    // MB(0,1): block0 mode 8 with B=3 from linebuf, A unavailable; rest mode 5
    start_mb(7'd0, 7'd1);
    run_block(0, 4'd8, 1'b0, 3'd7, 0, 1);
    for (int i = 1; i < 16; i++)
      run_block(i, 4'd5, pm[i], pm[i] ? 3'd0 : 3'd4, int'(xt[i] != 0), 1);
    finish_mb();

    // MB(1,1): block0 A=5 (left), B=3 (linebuf) -> pred 3, mode 3 matches
    start_mb(7'd1, 7'd1);
    run_block(0, 4'd3, 1'b1, 3'd0, 1, 1);

    // Backpressure on block 1 with a stray res_valid during ISSUE
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      check("bp blk_valid", blk_valid, 1);
      check("bp blk_idx", blk_idx, 1);
      check("bp blk_x", blk_x, 4);
      check("bp blk_y", blk_y, 0);
      check("bp mbAddrA_valid", mbAddrA_valid, 1);
      check("bp mbAddrB_valid", mbAddrB_valid, 1);
      check("bp mode_valid", mode_valid, 0);
      check("bp res_ready", res_ready, 0);
      if (c == 1) begin
        res_valid = 1'b1;
        res_mode = 4'd5;
      end else begin
        res_valid = 1'b0;
      end
      @(negedge clk);
    end
    res_valid = 1'b0;
    run_block(1, 4'd7, 1'b0, 3'd6, 1, 1);
    run_block(2, 4'd2, 1'b0, 3'd2, 1, 1);
    run_block(3, 4'd2, 1'b1, 3'd0, 1, 1);
    run_block(4, 4'd2, 1'b0, 3'd2, 1, 1);
    run_block(5, 4'd2, 1'b1, 3'd0, 1, 1);
    run_block(6, 4'd2, 1'b1, 3'd0, 1, 1);

    // Reset during WAIT_RES of block 7
    for (int k = 0; k < 20; k++) begin
      if (blk_valid) break;
      @(negedge clk);
    end
    check("b7 blk_idx", blk_idx, 7);
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    check("b7 res_ready", res_ready, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("mid-MB reset");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("no mb_done after reset", mb_done, 0);
      check("idle after reset", mb_busy, 0);
    end

    // Restart after reset begins at block 0
    start_mb(7'd0, 7'd0);
    check("restart blk_valid", blk_valid, 1);
    check("restart blk_idx", blk_idx, 0);
    check("restart blk_x", blk_x, 0);
    check("restart blk_y", blk_y, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
